// File: rtl/peripheral_dbg_pu_riscv_pkg.sv
// Shared types and derivation helpers for the RISC-V debug CPU mux.
package peripheral_dbg_pu_riscv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic int unsigned calc_ncores(input int unsigned x, input int unsigned y,
                                              input int unsigned z, input int unsigned cpt);
    return x * y * z * cpt;
  endfunction

  // Select width never collapses to zero, even for a single core.
  function automatic int unsigned calc_sw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_NCORES = calc_ncores(2, 2, 2, 4);
  localparam int unsigned DEF_SW     = calc_sw(DEF_NCORES);

endpackage

// File: rtl/peripheral_dbg_pu_riscv_bp_ctrl.sv
// Sticky per-core breakpoint flags and core stall generation.
module peripheral_dbg_pu_riscv_bp_ctrl #(
  parameter int unsigned NCORES    = 32,
  parameter int unsigned STALL_ALL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCORES-1:0] cpu_bp,
  input  logic [NCORES-1:0] bp_clr,
  input  logic [NCORES-1:0] stall_req,
  output logic [NCORES-1:0] bp_src,
  output logic              bp_any_c,
  output logic [NCORES-1:0] stall_c
);

  // A new breakpoint outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp_src <= '0;
    end else begin
      bp_src <= cpu_bp | (bp_src & ~bp_clr);
    end
  end

  assign bp_any_c = |bp_src;
  assign stall_c  = stall_req | ((STALL_ALL != 0) ? {NCORES{bp_any_c}} : bp_src);

endmodule

// File: rtl/peripheral_dbg_pu_riscv_cpu_mux.sv
// Debug-bus to per-core access multiplexer with ack timeout and breakpoint stall control.
module peripheral_dbg_pu_riscv_cpu_mux
  import peripheral_dbg_pu_riscv_pkg::*;
#(
  parameter int unsigned X              = 2,
  parameter int unsigned Y              = 2,
  parameter int unsigned Z              = 2,
  parameter int unsigned CORES_PER_TILE = 4,
  parameter int unsigned CPU_ADDR_WIDTH = 32,
  parameter int unsigned CPU_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned STALL_ALL      = 1,
  parameter int unsigned NCORES         = calc_ncores(X, Y, Z, CORES_PER_TILE),
  parameter int unsigned SW             = calc_sw(NCORES)
) (
  input  logic                                cpu_clk_i,
  input  logic                                cpu_rst_i,
  input  logic [SW-1:0]                       dbg_sel_i,
  input  logic [CPU_ADDR_WIDTH-1:0]           dbg_addr_i,
  input  logic [CPU_DATA_WIDTH-1:0]           dbg_data_i,
  input  logic                                dbg_we_i,
  input  logic                                dbg_stb_i,
  output logic [CPU_DATA_WIDTH-1:0]           dbg_data_o,
  output logic                                dbg_ack_o,
  output logic                                dbg_err_o,
  input  logic [NCORES-1:0]                   dbg_stall_req_i,
  input  logic [NCORES-1:0]                   dbg_bp_clr_i,
  output logic [NCORES-1:0]                   dbg_bp_src_o,
  output logic                                dbg_bp_o,
  output logic [NCORES*CPU_ADDR_WIDTH-1:0]    cpu_addr_o,
  output logic [NCORES*CPU_DATA_WIDTH-1:0]    cpu_data_o,
  input  logic [NCORES*CPU_DATA_WIDTH-1:0]    cpu_data_i,
  output logic [NCORES-1:0]                   cpu_we_o,
  output logic [NCORES-1:0]                   cpu_stb_o,
  input  logic [NCORES-1:0]                   cpu_ack_i,
  input  logic [NCORES-1:0]                   cpu_bp_i,
  output logic [NCORES-1:0]                   cpu_stall_o
);

  localparam int unsigned AW = CPU_ADDR_WIDTH;
  localparam int unsigned DW = CPU_DATA_WIDTH;
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SW-1:0]        sel_q, sel_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic                 we_q, we_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [NCORES-1:0]    stb_q, stb_d;
  logic [NCORES-1:0]    cwe_q, cwe_d;
  logic [NCORES*AW-1:0] caddr_q, caddr_d;
  logic [NCORES*DW-1:0] cdata_q, cdata_d;

  logic                 bad_sel_c;
  logic                 ack_sel_c;
  logic [DW-1:0]        sel_rdata_c;
  logic                 drive_c;
  logic [SW-1:0]        drv_sel_c;
  logic [AW-1:0]        drv_addr_c;
  logic [DW-1:0]        drv_data_c;
  logic                 drv_we_c;

  // Only a non-power-of-two core count leaves select codes without a core.
  if (NCORES < (32'd1 << SW)) begin : g_sel_chk
    assign bad_sel_c = (dbg_sel_i >= SW'(NCORES));
  end else begin : g_sel_full
    assign bad_sel_c = 1'b0;
  end

  assign ack_sel_c = cpu_ack_i[sel_q];

  always_comb begin
    sel_rdata_c = '0;
    for (int unsigned i = 0; i < NCORES; i++) begin
      if (sel_q == SW'(i)) sel_rdata_c = cpu_data_i[i*DW +: DW];
    end
  end

  always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
    if (cpu_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      stb_q   <= '0;
      cwe_q   <= '0;
      caddr_q <= '0;
      cdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      stb_q   <= stb_d;
      cwe_q   <= cwe_d;
      caddr_q <= caddr_d;
      cdata_q <= cdata_d;
    end
  end

  // Next state plus the core-side bus values that will be registered for the next cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    rdata_d    = rdata_q;
    ack_d      = 1'b0;
    err_d      = err_q;
    drive_c    = 1'b0;
    drv_sel_c  = sel_q;
    drv_addr_c = addr_q;
    drv_data_c = wdata_q;
    drv_we_c   = we_q;
    stb_d      = '0;
    cwe_d      = '0;
    caddr_d    = '0;
    cdata_d    = '0;

    unique case (state_q)
      IDLE: begin
        if (dbg_stb_i) begin
          if (bad_sel_c) begin
            state_d = DONE;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d    = ACCESS;
            cnt_d      = '0;
            sel_d      = dbg_sel_i;
            addr_d     = dbg_addr_i;
            wdata_d    = dbg_data_i;
            we_d       = dbg_we_i;
            drive_c    = 1'b1;
            drv_sel_c  = dbg_sel_i;
            drv_addr_c = dbg_addr_i;
            drv_data_c = dbg_data_i;
            drv_we_c   = dbg_we_i;
          end
        end
      end
      ACCESS: begin
        if (ack_sel_c) begin
          state_d = DONE;
          ack_d   = 1'b1;
          err_d   = 1'b0;
          if (!we_q) rdata_d = sel_rdata_c;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          ack_d   = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          drive_c = 1'b1;
        end
      end
      DONE: begin
        if (dbg_stb_i) ack_d = 1'b1;
        else           state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    for (int unsigned i = 0; i < NCORES; i++) begin
      if (drive_c && (drv_sel_c == SW'(i))) begin
        stb_d[i]             = 1'b1;
        cwe_d[i]             = drv_we_c;
        caddr_d[i*AW +: AW]  = drv_addr_c;
        cdata_d[i*DW +: DW]  = drv_data_c;
      end
    end
  end

  assign dbg_data_o = rdata_q;
  assign dbg_ack_o  = ack_q;
  assign dbg_err_o  = err_q;
  assign cpu_stb_o  = stb_q;
  assign cpu_we_o   = cwe_q;
  assign cpu_addr_o = caddr_q;
  assign cpu_data_o = cdata_q;

  peripheral_dbg_pu_riscv_bp_ctrl #(
    .NCORES    (NCORES),
    .STALL_ALL (STALL_ALL)
  ) u_bp_ctrl (
    .clk       (cpu_clk_i),
    .rst       (cpu_rst_i),
    .cpu_bp    (cpu_bp_i),
    .bp_clr    (dbg_bp_clr_i),
    .stall_req (dbg_stall_req_i),
    .bp_src    (dbg_bp_src_o),
    .bp_any_c  (dbg_bp_o),
    .stall_c   (cpu_stall_o)
  );

endmodule

// File: tb/tb_peripheral_dbg_pu_riscv_cpu_mux.sv
// Randomized self-checking bench: a 32-core stall-all mux and a 6-core per-core-stall mux.
module tb_peripheral_dbg_pu_riscv_cpu_mux;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned NA   = 32;
  localparam int unsigned SWA  = 5;
  localparam int unsigned TO_A = 8;
  localparam int unsigned NB   = 6;
  localparam int unsigned SWB  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [SWA-1:0]     a_sel;
  logic [AW-1:0]      a_addr;
  logic [DW-1:0]      a_wdata, a_rdata;
  logic               a_we, a_stb, a_ack, a_err, a_bp;
  logic [NA-1:0]      a_stall_req, a_bp_clr, a_bp_src;
  logic [NA*AW-1:0]   a_cpu_addr;
  logic [NA*DW-1:0]   a_cpu_wdata, a_cpu_rdata;
  logic [NA-1:0]      a_cpu_we, a_cpu_stb, a_cpu_ack, a_cpu_bp, a_cpu_stall;
  logic [DW-1:0]      a_exp_rdata;

  logic [SWB-1:0]     b_sel;
  logic [AW-1:0]      b_addr;
  logic [DW-1:0]      b_wdata, b_rdata;
  logic               b_we, b_stb, b_ack, b_err, b_bp;
  logic [NB-1:0]      b_stall_req, b_bp_clr, b_bp_src;
  logic [NB*AW-1:0]   b_cpu_addr;
  logic [NB*DW-1:0]   b_cpu_wdata, b_cpu_rdata;
  logic [NB-1:0]      b_cpu_we, b_cpu_stb, b_cpu_ack, b_cpu_bp, b_cpu_stall;

  peripheral_dbg_pu_riscv_cpu_mux #(
    .X(2), .Y(2), .Z(2), .CORES_PER_TILE(4), .CPU_ADDR_WIDTH(AW), .CPU_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO_A), .STALL_ALL(1)
  ) dut_a (
    .cpu_clk_i(clk), .cpu_rst_i(rst), .dbg_sel_i(a_sel), .dbg_addr_i(a_addr),
    .dbg_data_i(a_wdata), .dbg_we_i(a_we), .dbg_stb_i(a_stb), .dbg_data_o(a_rdata),
    .dbg_ack_o(a_ack), .dbg_err_o(a_err), .dbg_stall_req_i(a_stall_req),
    .dbg_bp_clr_i(a_bp_clr), .dbg_bp_src_o(a_bp_src), .dbg_bp_o(a_bp),
    .cpu_addr_o(a_cpu_addr), .cpu_data_o(a_cpu_wdata), .cpu_data_i(a_cpu_rdata),
    .cpu_we_o(a_cpu_we), .cpu_stb_o(a_cpu_stb), .cpu_ack_i(a_cpu_ack),
    .cpu_bp_i(a_cpu_bp), .cpu_stall_o(a_cpu_stall)
  );

  peripheral_dbg_pu_riscv_cpu_mux #(
    .X(1), .Y(1), .Z(1), .CORES_PER_TILE(6), .CPU_ADDR_WIDTH(AW), .CPU_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO_A), .STALL_ALL(0)
  ) dut_b (
    .cpu_clk_i(clk), .cpu_rst_i(rst), .dbg_sel_i(b_sel), .dbg_addr_i(b_addr),
    .dbg_data_i(b_wdata), .dbg_we_i(b_we), .dbg_stb_i(b_stb), .dbg_data_o(b_rdata),
    .dbg_ack_o(b_ack), .dbg_err_o(b_err), .dbg_stall_req_i(b_stall_req),
    .dbg_bp_clr_i(b_bp_clr), .dbg_bp_src_o(b_bp_src), .dbg_bp_o(b_bp),
    .cpu_addr_o(b_cpu_addr), .cpu_data_o(b_cpu_wdata), .cpu_data_i(b_cpu_rdata),
    .cpu_we_o(b_cpu_we), .cpu_stb_o(b_cpu_stb), .cpu_ack_i(b_cpu_ack),
    .cpu_bp_i(b_cpu_bp), .cpu_stall_o(b_cpu_stall)
  );

  // One debugger access on dut_a; the bench acts as every core. ack_at = N means the
  // selected core acks during the N-th cycle its strobe is high (out of range = never).
  task automatic access_a(input logic [SWA-1:0] sel, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic we,
                          input logic [DW-1:0] rdata, input int ack_at, input string name);
    logic [NA*AW-1:0] exp_addr;
    logic [NA*DW-1:0] exp_wdata;
    logic [NA-1:0]    exp_stb, exp_we;
    int  stb_cycles = 0;
    int  exp_cycles;
    bit  done = 1'b0;
    bit  exp_err;
    int  hold;
    exp_addr  = (NA*AW)'(addr)  << (int'(sel) * AW);
    exp_wdata = (NA*DW)'(wdata) << (int'(sel) * DW);
    exp_stb   = NA'(1) << sel;
    exp_we    = we ? exp_stb : '0;
    exp_err   = !(ack_at >= 1 && ack_at <= int'(TO_A));
    exp_cycles = exp_err ? int'(TO_A) : ack_at;

    @(negedge clk);
    a_sel = sel; a_addr = addr; a_wdata = wdata; a_we = we; a_stb = 1'b1;
    for (int cyc = 0; cyc < int'(TO_A) + 4 && !done; cyc++) begin
      @(negedge clk);
      a_cpu_ack = '0;
      if (a_ack) begin
        done = 1'b1;
      end else if (a_cpu_stb != '0) begin
        stb_cycles++;
        n_checks++;
        if (a_cpu_stb !== exp_stb || a_cpu_addr !== exp_addr ||
            a_cpu_wdata !== exp_wdata || a_cpu_we !== exp_we) begin
          n_fail++;
          $display("FAIL %s core bus cycle %0d: stb=%h we=%h (want stb=%h we=%h) or addr/data slices wrong",
                   name, stb_cycles, a_cpu_stb, a_cpu_we, exp_stb, exp_we);
        end
        for (int i = 0; i < int'(NA); i++)
          a_cpu_rdata[i*DW +: DW] = (i == int'(sel)) ? rdata : DW'($urandom);
        if (stb_cycles == ack_at) a_cpu_ack[sel] = 1'b1;
        a_cpu_ack[(int'(sel) + 1) % int'(NA)] = 1'($urandom_range(0, 1));
      end
    end
    a_cpu_ack = '0;

    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s no dbg_ack_o within %0d cycles", name, TO_A + 4);
    end
    n_checks++;
    if (stb_cycles != exp_cycles) begin
      n_fail++;
      $display("FAIL %s strobe length got %0d want %0d", name, stb_cycles, exp_cycles);
    end
    n_checks++;
    if (a_err !== exp_err) begin
      n_fail++;
      $display("FAIL %s dbg_err_o got %b want %b", name, a_err, exp_err);
    end
    if (!exp_err && !we) a_exp_rdata = rdata;
    n_checks++;
    if (a_rdata !== a_exp_rdata) begin
      n_fail++;
      $display("FAIL %s dbg_data_o got %h want %h", name, a_rdata, a_exp_rdata);
    end

    hold = $urandom_range(1, 3);
    repeat (hold) begin
      @(negedge clk);
      n_checks++;
      if (a_ack !== 1'b1 || a_err !== exp_err || a_cpu_stb !== '0 || a_rdata !== a_exp_rdata) begin
        n_fail++;
        $display("FAIL %s hold ack=%b err=%b stb=%h data=%h want ack=1 err=%b stb=0 data=%h",
                 name, a_ack, a_err, a_cpu_stb, a_rdata, exp_err, a_exp_rdata);
      end
    end
    a_stb = 1'b0;
    @(negedge clk);
    n_checks++;
    if (a_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL %s release dbg_ack_o got %b want 0", name, a_ack);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_sel = '0; a_addr = '0; a_wdata = '0; a_we = 1'b0; a_stb = 1'b0;
    a_bp_clr = '0; a_cpu_rdata = '0; a_cpu_ack = '0; a_cpu_bp = '0;
    b_sel = '0; b_addr = '0; b_wdata = '0; b_we = 1'b0; b_stb = 1'b0;
    b_bp_clr = '0; b_cpu_rdata = '0; b_cpu_ack = '0; b_cpu_bp = '0;
    a_stall_req = NA'($urandom);
    b_stall_req = NB'($urandom);
    a_exp_rdata = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (a_cpu_stb !== '0 || a_cpu_we !== '0 || a_cpu_addr !== '0 || a_cpu_wdata !== '0 ||
        a_ack !== 1'b0 || a_err !== 1'b0 || a_rdata !== '0 || a_bp_src !== '0 || a_bp !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_a outputs stb=%h ack=%b err=%b data=%h bp_src=%h want all zero",
               a_cpu_stb, a_ack, a_err, a_rdata, a_bp_src);
    end
    n_checks++;
    if (a_cpu_stall !== a_stall_req || b_cpu_stall !== b_stall_req) begin
      n_fail++;
      $display("FAIL reset_stall a=%h (want %h) b=%h (want %h)", a_cpu_stall, a_stall_req,
               b_cpu_stall, b_stall_req);
    end
    n_checks++;
    if (b_cpu_stb !== '0 || b_ack !== 1'b0 || b_err !== 1'b0 || b_bp_src !== '0) begin
      n_fail++;
      $display("FAIL reset_b outputs stb=%h ack=%b err=%b bp_src=%h want zero",
               b_cpu_stb, b_ack, b_err, b_bp_src);
    end
    rst = 1'b0;
    a_stall_req = '0;
    b_stall_req = '0;
  endtask

  task automatic test_read();
    access_a(5'd5, 32'h0000_0100, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF, 3, "read_core5");
    access_a(5'd9, 32'h0000_0200, 32'h0, 1'b0, 32'hCAFE_F00D, 1, "read_min_latency");
  endtask

  task automatic test_timeout();
    access_a(5'd2, 32'h0000_0040, 32'h0, 1'b0, 32'h5555_AAAA, 0, "timeout_core2");
    access_a(5'd31, 32'h0000_0044, 32'h0, 1'b0, 32'h0BAD_CAFE, int'(TO_A), "ack_on_last_cycle");
  endtask

  task automatic test_random_access();
    for (int k = 0; k < 10; k++) begin
      access_a(SWA'($urandom_range(0, NA - 1)), AW'($urandom), DW'($urandom),
               1'($urandom_range(0, 1)), DW'($urandom), $urandom_range(1, TO_A + 1), "random_access");
    end
    access_a(5'd0, 32'h10, 32'hFEED_0001, 1'b1, 32'h7777_7777, 2, "write_keeps_data");
  endtask

  task automatic test_breakpoint();
    logic [NA-1:0] model;
    @(negedge clk);
    a_stall_req = '0; a_cpu_bp = '0; a_bp_clr = '0;
    a_cpu_bp[7] = 1'b1;
    @(negedge clk);
    a_cpu_bp = '0;
    n_checks++;
    if (a_bp_src !== 32'h80 || a_cpu_stall !== '1 || a_bp !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_set src=%h stall=%h bp=%b want src=00000080 stall=ffffffff bp=1",
               a_bp_src, a_cpu_stall, a_bp);
    end
    a_cpu_bp[7] = 1'b1; a_bp_clr[7] = 1'b1;
    @(negedge clk);
    a_cpu_bp = '0;
    n_checks++;
    if (a_bp_src !== 32'h80) begin
      n_fail++;
      $display("FAIL bp_set_wins src=%h want 00000080", a_bp_src);
    end
    a_stall_req = NA'($urandom);
    @(negedge clk);
    a_bp_clr = '0;
    n_checks++;
    if (a_bp_src !== '0 || a_cpu_stall !== a_stall_req) begin
      n_fail++;
      $display("FAIL bp_clear src=%h stall=%h want src=0 stall=%h", a_bp_src, a_cpu_stall, a_stall_req);
    end
    model = '0;
    for (int k = 0; k < 30; k++) begin
      a_cpu_bp    = NA'($urandom & $urandom & $urandom);
      a_bp_clr    = NA'($urandom);
      a_stall_req = NA'($urandom & $urandom & $urandom);
      for (int i = 0; i < int'(NA); i++) begin
        if (a_cpu_bp[i])      model[i] = 1'b1;
        else if (a_bp_clr[i]) model[i] = 1'b0;
      end
      @(negedge clk);
      n_checks++;
      if (a_bp_src !== model || a_cpu_stall !== (a_stall_req | ((model != '0) ? '1 : '0))) begin
        n_fail++;
        $display("FAIL bp_random step %0d src=%h stall=%h want src=%h", k, a_bp_src, a_cpu_stall, model);
      end
    end
    a_cpu_bp = '0; a_bp_clr = '0; a_stall_req = '0;
  endtask

  task automatic test_core_b();
    logic [NB-1:0] model;
    bit seen;
    @(negedge clk);
    b_stall_req = '0; b_cpu_bp = 6'b000010;
    @(negedge clk);
    b_cpu_bp = '0;
    n_checks++;
    if (b_cpu_stall !== 6'b000010 || b_bp_src !== 6'b000010 || b_bp !== 1'b1) begin
      n_fail++;
      $display("FAIL b_local_stall stall=%b src=%b bp=%b want 000010 000010 1", b_cpu_stall, b_bp_src, b_bp);
    end
    model = 6'b000010;
    for (int k = 0; k < 12; k++) begin
      b_cpu_bp    = NB'($urandom & $urandom);
      b_bp_clr    = NB'($urandom);
      b_stall_req = NB'($urandom & $urandom);
      for (int i = 0; i < int'(NB); i++) begin
        if (b_cpu_bp[i])      model[i] = 1'b1;
        else if (b_bp_clr[i]) model[i] = 1'b0;
      end
      @(negedge clk);
      n_checks++;
      if (b_bp_src !== model || b_cpu_stall !== (b_stall_req | model)) begin
        n_fail++;
        $display("FAIL b_bp_random step %0d src=%b stall=%b want src=%b stall=%b",
                 k, b_bp_src, b_cpu_stall, model, b_stall_req | model);
      end
    end
    b_cpu_bp = '0; b_bp_clr = '0; b_stall_req = '0;

    for (int t = 0; t < 2; t++) begin
      b_sel = (t == 0) ? 3'd7 : 3'd6;
      b_addr = AW'($urandom); b_we = 1'($urandom_range(0, 1)); b_stb = 1'b1;
      seen = 1'b0;
      for (int cyc = 0; cyc < 4; cyc++) begin
        @(negedge clk);
        n_checks++;
        if (b_cpu_stb !== '0) begin
          n_fail++;
          $display("FAIL b_bad_index sel=%0d cpu_stb_o=%b want 000000", b_sel, b_cpu_stb);
        end
        if (cyc == 0) seen = b_ack;
      end
      n_checks++;
      if (seen !== 1'b1 || b_ack !== 1'b1 || b_err !== 1'b1) begin
        n_fail++;
        $display("FAIL b_bad_index_err sel=%0d first_ack=%b ack=%b err=%b want 1 1 1",
                 b_sel, seen, b_ack, b_err);
      end
      b_stb = 1'b0;
      @(negedge clk);
      n_checks++;
      if (b_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL b_bad_index_release ack=%b want 0", b_ack);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    a_sel = '0; a_addr = 32'h0000_0300; a_wdata = 32'hA5A5_5A5A; a_we = 1'b1; a_stb = 1'b1;
    a_cpu_bp = '0; a_cpu_bp[3] = 1'b1;
    @(negedge clk);
    a_cpu_bp = '0;
    @(negedge clk);
    n_checks++;
    if (a_cpu_stb !== 32'h1 || a_cpu_we !== 32'h1) begin
      n_fail++;
      $display("FAIL pre_reset_write stb=%h we=%h want 00000001 00000001", a_cpu_stb, a_cpu_we);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (a_cpu_stb !== '0 || a_cpu_we !== '0 || a_cpu_addr !== '0 || a_ack !== 1'b0 ||
        a_rdata !== '0 || a_bp_src !== '0) begin
      n_fail++;
      $display("FAIL async_reset stb=%h we=%h ack=%b data=%h bp_src=%h want all zero",
               a_cpu_stb, a_cpu_we, a_ack, a_rdata, a_bp_src);
    end
    a_exp_rdata = '0;
    @(negedge clk);
    a_stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (a_ack !== 1'b0 || a_cpu_stb !== '0) begin
      n_fail++;
      $display("FAIL post_reset_quiet ack=%b stb=%h want 0 0", a_ack, a_cpu_stb);
    end
    access_a(5'd0, 32'h0000_0304, 32'h0F0F_F0F0, 1'b1, 32'h1111_2222, 2, "write_after_reset");
  endtask

  initial begin
    test_reset();
    test_read();
    test_timeout();
    test_random_access();
    test_breakpoint();
    test_core_b();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/peripheral_dbg_pu_riscv_cpu_mux.md
PERIPHERAL_DBG_PU_RISCV_CPU_MUX -- requirements
Module: peripheral_dbg_pu_riscv_cpu_mux

Interface
REQ-001 SHALL have these parameters (name, default, meaning):
- X 2, Y 2, Z 2, CORES_PER_TILE 4: mesh shape; NCORES = X*Y*Z*CORES_PER_TILE.
- CPU_ADDR_WIDTH 32: address width.
- CPU_DATA_WIDTH 32: data width.
- TIMEOUT_CYCLES 255: maximum number of cycles to wait for an ack.
- STALL_ALL 1: 1 = any breakpoint stalls all cores; 0 = a breakpoint stalls only its own core.
- SW: derived, $clog2(NCORES).
REQ-002 SHALL have these ports (name, direction, width, meaning); one clock, asynchronous active-high reset:
- cpu_clk_i, in, 1: clock.
- cpu_rst_i, in, 1: asynchronous active-high reset.
- dbg_sel_i, in, SW: target core index.
- dbg_addr_i, in, CPU_ADDR_WIDTH: access address.
- dbg_data_i, in, CPU_DATA_WIDTH: write data.
- dbg_we_i, in, 1: 1 = write.
- dbg_stb_i, in, 1: request strobe (4-phase).
- dbg_data_o, out, CPU_DATA_WIDTH: read data.
- dbg_ack_o, out, 1: access complete.
- dbg_err_o, out, 1: access failed (timeout or bad index).
- dbg_stall_req_i, in, NCORES: per-core stall request from the debug unit.
- dbg_bp_clr_i, in, NCORES: per-core breakpoint clear.
- dbg_bp_src_o, out, NCORES: sticky per-core breakpoint flags.
- dbg_bp_o, out, 1: OR of dbg_bp_src_o.
- cpu_addr_o, out, NCORES*CPU_ADDR_WIDTH: per-core address.
- cpu_data_o, out, NCORES*CPU_DATA_WIDTH: per-core write data.
- cpu_data_i, in, NCORES*CPU_DATA_WIDTH: per-core read data.
- cpu_we_o, out, NCORES: per-core write enable.
- cpu_stb_o, out, NCORES: per-core strobe.
- cpu_ack_i, in, NCORES: per-core ack.
- cpu_bp_i, in, NCORES: per-core breakpoint.
- cpu_stall_o, out, NCORES: per-core stall.

Function
REQ-003 SHALL run an FSM with states IDLE, ACCESS, DONE.
REQ-004 IDLE with dbg_stb_i=1 and dbg_sel_i<NCORES: latch sel/addr/data/we, clear the timeout counter, go to ACCESS next cycle.
REQ-005 IDLE with dbg_stb_i=1 and dbg_sel_i>=NCORES: go to DONE with err=1; no cpu_stb_o is asserted.
REQ-006 In ACCESS, only cpu_stb_o[sel] SHALL be 1; cpu_we_o[sel], cpu_addr_o slice and cpu_data_o slice SHALL carry the latched values; all other slices SHALL be 0.
REQ-007 ACCESS with cpu_ack_i[sel]=1: capture the cpu_data_i slice into dbg_data_o (reads only; on writes dbg_data_o holds its value), err=0, go to DONE; cpu_stb_o drops the same cycle DONE is entered.
REQ-008 ACCESS: the counter increments each cycle without an ack; once it equals TIMEOUT_CYCLES-1 without an ack, go to DONE with err=1. Ack on that same cycle wins (err=0).
REQ-009 Acks from non-selected cores SHALL be ignored.
REQ-010 DONE: dbg_ack_o=1 and dbg_err_o valid, held until dbg_stb_i=0; then return to IDLE. A minimum of one IDLE cycle SHALL separate accesses.
REQ-011 Minimum access latency: stb sampled in cycle 0 -> cpu_stb_o from cycle 1 -> ack in cycle 1 -> dbg_ack_o in cycle 2.
REQ-012 dbg_bp_src_o[i] SHALL set on the clock after cpu_bp_i[i]=1 and clear on the clock after dbg_bp_clr_i[i]=1; set wins when both occur together.
REQ-013 cpu_stall_o SHALL equal dbg_stall_req_i OR (STALL_ALL ? {NCORES{dbg_bp_o}} : dbg_bp_src_o); combinational from registers and inputs; no ACCESS dependency.
REQ-014 Accesses to stalled cores SHALL proceed normally (the debugger needs them).

Reset
REQ-015 cpu_rst_i=1 SHALL asynchronously force IDLE, counter=0, dbg_bp_src_o=0, dbg_data_o=0, dbg_ack_o=0, dbg_err_o=0, and all cpu_stb_o/cpu_we_o/cpu_addr_o/cpu_data_o=0.
REQ-016 cpu_stall_o SHALL then equal dbg_stall_req_i.
REQ-017 Reset mid-ACCESS SHALL drop cpu_stb_o immediately and produce no dbg_ack_o.

Structure
REQ-018 Package peripheral_dbg_pu_riscv_pkg SHALL hold the FSM state enum (IDLE, ACCESS, DONE) and the NCORES/SW derivation constants.
REQ-019 Breakpoint latching and stall generation SHALL live in the sub-module peripheral_dbg_pu_riscv_bp_ctrl (parameters NCORES, STALL_ALL); the access FSM and timeout logic stay in the top.

Verification
REQ-020 Read: sel=5, addr=0x0000_0100, core 5 acks 3 cycles after stb with data 0xDEAD_BEEF -> only cpu_stb_o[5] high for 3 cycles; dbg_data_o=0xDEAD_BEEF, dbg_ack_o=1, dbg_err_o=0 held until stb drops.
REQ-021 Timeout: TIMEOUT_CYCLES=8, sel=2, no ack -> cpu_stb_o[2] high exactly 8 cycles, then dbg_ack_o=1, dbg_err_o=1; a spurious cpu_ack_i[3] during the access is ignored.
REQ-022 Breakpoint: STALL_ALL=1, cpu_bp_i[7] pulse 1 cycle -> next cycle dbg_bp_src_o=32'h80, cpu_stall_o=all ones; dbg_bp_clr_i[7] together with cpu_bp_i[7] -> flag stays 1; clear alone -> cpu_stall_o = dbg_stall_req_i.
REQ-023 STALL_ALL=0, NCORES=6 (X=1, Y=1, Z=1, CORES_PER_TILE=6): cpu_bp_i[1] -> cpu_stall_o=6'b000010; sel=7 -> dbg_err_o=1, no cpu_stb_o activity.
REQ-024 Reset asserted 2 cycles into a write to core 0 -> cpu_stb_o[0]=0 asynchronously, no dbg_ack_o, FSM IDLE; the next write after reset completes normally.
